imem_loader: RTL and testbench

- Writer side of the instruction-memory fetch interface.
- Accepts a framed byte stream from a host link (UART/JTAG bridge) over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes those words into instruction memory at PC-style byte addresses.
- Holds the CPU in reset until a complete, checksum-verified image is loaded.

---
 rtl/imem_loader.sv | 150 +++++++++++++++
 tb/tb_imem_loader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader
// Writer side of the instruction-memory fetch interface. Receives a framed
// byte stream from a host link, assembles little-endian 32-bit words, writes
// them to instruction memory at byte addresses starting at BASE_ADDR, and
// holds the CPU in reset until a complete, checksum-verified image is loaded.
//
// Frame: LEN_LO, LEN_HI, 4*N data bytes (LSB of each word first), CSUM.
// CSUM is the XOR of every preceding byte of the frame.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous, active-high reset
//   start_i      begin a new load (honoured in IDLE, DONE or ERR only)
//   byte_valid_i host byte available
//   byte_data_i  host byte
//   byte_ready_o loader accepts a byte this cycle
//   mem_we_o     one-cycle instruction-memory write strobe
//   mem_addr_o   word-aligned write byte address
//   mem_data_o   write data
//   cpu_hold_o   1 = CPU held in reset (0 only in DONE)
//   busy_o       load in progress
//   done_o       image loaded and verified
//   err_o        load failed (oversize image or bad checksum)
//   word_cnt_o   words written in the current or last load
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        cpu_hold_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] word_cnt_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN0 = 3'd1;
  localparam logic [2:0] S_LEN1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  logic [2:0]  state;
  logic [7:0]  len_lo;
  logic [15:0] n_words;
  logic [7:0]  xor_acc;
  logic [1:0]  byte_idx;
  logic [23:0] word_asm;
  logic [15:0] word_cnt;
  logic [15:0] len_full;
  logic        accept;
  logic        last_word;

  // Status outputs are pure decodes of the state register, so an
  // asynchronous reset drives them to their idle values immediately.
  assign byte_ready_o = (state == S_LEN0) || (state == S_LEN1) ||
                        (state == S_DATA) || (state == S_CSUM);
  assign busy_o       = byte_ready_o;
  assign done_o       = (state == S_DONE);
  assign err_o        = (state == S_ERR);
  assign cpu_hold_o   = (state != S_DONE);
  assign word_cnt_o   = word_cnt;

  assign accept    = byte_valid_i && byte_ready_o;
  assign len_full  = {byte_data_i, len_lo};
  // Only evaluated in DATA, where n_words is at least 1.
  assign last_word = (word_cnt == (n_words - 16'd1));

  // word_cnt doubles as the word index: it equals the number of words
  // already written, which is exactly the index of the word being built.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      len_lo     <= 8'd0;
      n_words    <= 16'd0;
      xor_acc    <= 8'd0;
      byte_idx   <= 2'd0;
      word_asm   <= 24'd0;
      word_cnt   <= 16'd0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= BASE_ADDR;
      mem_data_o <= 32'd0;
    end else begin
      mem_we_o <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state    <= S_LEN0;
            word_cnt <= 16'd0;
            xor_acc  <= 8'd0;
            byte_idx <= 2'd0;
          end
        end
        S_LEN0: begin
          if (accept) begin
            len_lo  <= byte_data_i;
            xor_acc <= xor_acc ^ byte_data_i;
            state   <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (accept) begin
            n_words <= len_full;
            xor_acc <= xor_acc ^ byte_data_i;
            if ({16'd0, len_full} > DEPTH_WORDS)
              state <= S_ERR;
            else if (len_full == 16'd0)
              state <= S_CSUM;
            else
              state <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            xor_acc <= xor_acc ^ byte_data_i;
            if (byte_idx == 2'd3) begin
              // Earlier bytes sit in word_asm LSB-first; this byte is b3.
              mem_we_o   <= 1'b1;
              mem_addr_o <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
              mem_data_o <= {byte_data_i, word_asm};
              word_cnt   <= word_cnt + 16'd1;
              byte_idx   <= 2'd0;
              if (last_word)
                state <= S_CSUM;
            end else begin
              word_asm <= {byte_data_i, word_asm[23:8]};
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        S_CSUM: begin
          if (accept)
            state <= (byte_data_i == xor_acc) ? S_DONE : S_ERR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Directed self-checking bench for imem_loader: a table of whole-frame
// vectors with expected results, plus hand sequences for handshake timing,
// oversize rejection, host throttling and reset in the middle of a frame.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        cpu_hold_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] word_cnt_o;

  int assertions = 0;
  int failures   = 0;
  int accept_cnt = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  typedef struct {
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  csum_flip;
    logic        exp_done;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[5];

  imem_loader #(
    .DEPTH_WORDS(256),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .byte_valid_i(byte_valid_i),
    .byte_data_i (byte_data_i),
    .byte_ready_o(byte_ready_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .cpu_hold_o  (cpu_hold_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .word_cnt_o  (word_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // The strobe is high for a whole cycle, so one falling-edge sample
  // records each write exactly once.
  always @(negedge clk_i) begin
    if (mem_we_o) begin
      wr_addr_q.push_back(mem_addr_o);
      wr_data_q.push_back(mem_data_o);
    end
  end

  always @(posedge clk_i) begin
    if (byte_valid_i && byte_ready_o)
      accept_cnt++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Presents a byte from a falling edge; returns once byte_ready_o is seen
  // high, so the byte is taken on the following rising edge.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    @(negedge clk_i);
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    waited = 0;
    while (!byte_ready_o && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    if (waited >= 50)
      checkOutput("ready_timeout", 32'(byte_ready_o), 32'd1);
  endtask

  task automatic idle_host();
    @(negedge clk_i);
    byte_valid_i = 1'b0;
  endtask

  function automatic logic [7:0] frame_csum(input logic [15:0] n,
                                            input logic [31:0] w0,
                                            input logic [31:0] w1);
    logic [7:0] x;
    x = n[7:0] ^ n[15:8];
    if (n >= 16'd1) x = x ^ w0[7:0] ^ w0[15:8] ^ w0[23:16] ^ w0[31:24];
    if (n >= 16'd2) x = x ^ w1[7:0] ^ w1[15:8] ^ w1[23:16] ^ w1[31:24];
    return x;
  endfunction

  task automatic applyStimulus(input vec_t v);
    logic [15:0] n;
    logic [31:0] word;
    n = 16'(v.n);
    clear_writes();
    pulse_start();
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int i = 0; i < v.n; i++) begin
      word = (i == 0) ? v.w0 : v.w1;
      for (int b = 0; b < 4; b++)
        send_byte(word[8*b +: 8]);
    end
    send_byte(frame_csum(n, v.w0, v.w1) ^ v.csum_flip);
    idle_host();
    repeat (2) @(negedge clk_i);
  endtask

  task automatic check_vector(input int idx, input vec_t v);
    logic [31:0] word;
    string tag;
    tag = $sformatf("vec%0d", idx);
    checkOutput({tag, "_done"}, 32'(done_o), 32'(v.exp_done));
    checkOutput({tag, "_err"}, 32'(err_o), 32'(!v.exp_done));
    checkOutput({tag, "_hold"}, 32'(cpu_hold_o), 32'(!v.exp_done));
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
    checkOutput({tag, "_wcnt"}, 32'(word_cnt_o), 32'(v.exp_cnt));
    checkOutput({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(v.exp_cnt));
    for (int i = 0; i < v.exp_cnt && i < wr_addr_q.size(); i++) begin
      word = (i == 0) ? v.w0 : v.w1;
      checkOutput($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], BASE + 32'(4 * i));
      checkOutput($sformatf("%s_data%0d", tag, i), wr_data_q[i], word);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc0;
    logic [7:0] cs;

    vecs[0] = '{n: 2, w0: 32'h00A00513, w1: 32'h00B505B3, csum_flip: 8'h00, exp_done: 1'b1, exp_cnt: 2};
    vecs[1] = '{n: 2, w0: 32'h00A00513, w1: 32'h00B505B3, csum_flip: 8'h06, exp_done: 1'b0, exp_cnt: 2};
    vecs[2] = '{n: 0, w0: 32'h0,        w1: 32'h0,        csum_flip: 8'h00, exp_done: 1'b1, exp_cnt: 0};
    vecs[3] = '{n: 1, w0: 32'hDEADBEEF, w1: 32'h0,        csum_flip: 8'h00, exp_done: 1'b1, exp_cnt: 1};
    vecs[4] = '{n: 2, w0: 32'h12345678, w1: 32'hFFFFFFFF, csum_flip: 8'h80, exp_done: 1'b0, exp_cnt: 2};

    rst_i        = 1'b1;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;

    // Reset values while reset is held.
    repeat (2) @(negedge clk_i);
    checkOutput("rst_ready", 32'(byte_ready_o), 32'd0);
    checkOutput("rst_we", 32'(mem_we_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_err", 32'(err_o), 32'd0);
    checkOutput("rst_hold", 32'(cpu_hold_o), 32'd1);
    checkOutput("rst_addr", mem_addr_o, BASE);
    checkOutput("rst_data", mem_data_o, 32'd0);
    checkOutput("rst_wcnt", 32'(word_cnt_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("idle_ready", 32'(byte_ready_o), 32'd0);

    // Nominal frame by hand: cpu_hold_o must drop right after CSUM is taken.
    clear_writes();
    pulse_start();
    checkOutput("len0_ready", 32'(byte_ready_o), 32'd1);
    checkOutput("len0_busy", 32'(busy_o), 32'd1);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
    send_byte(8'hB3); send_byte(8'h05); send_byte(8'hB5); send_byte(8'h00);
    cs = frame_csum(16'd2, 32'h00A00513, 32'h00B505B3);
    send_byte(cs);
    checkOutput("pre_csum_hold", 32'(cpu_hold_o), 32'd1);
    checkOutput("pre_csum_done", 32'(done_o), 32'd0);
    idle_host();
    checkOutput("post_csum_hold", 32'(cpu_hold_o), 32'd0);
    checkOutput("post_csum_done", 32'(done_o), 32'd1);
    checkOutput("nom_nwrites", 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() == 2) begin
      checkOutput("nom_addr0", wr_addr_q[0], 32'h0);
      checkOutput("nom_data0", wr_data_q[0], 32'h00A00513);
      checkOutput("nom_addr1", wr_addr_q[1], 32'h4);
      checkOutput("nom_data1", wr_data_q[1], 32'h00B505B3);
    end

    // Table of whole frames; each starts from the DONE/ERR left by the last.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      check_vector(i, vecs[i]);
    end

    // Oversize image: 0x0101 words exceeds capacity, rejected after LEN_HI.
    clear_writes();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01);
    idle_host();
    checkOutput("ovr_err", 32'(err_o), 32'd1);
    checkOutput("ovr_ready", 32'(byte_ready_o), 32'd0);
    checkOutput("ovr_busy", 32'(busy_o), 32'd0);
    checkOutput("ovr_hold", 32'(cpu_hold_o), 32'd1);
    acc0 = accept_cnt;
    byte_valid_i = 1'b1;
    byte_data_i  = 8'h55;
    repeat (3) @(negedge clk_i);
    byte_valid_i = 1'b0;
    checkOutput("ovr_no_accept", 32'(accept_cnt - acc0), 32'd0);
    checkOutput("ovr_nwrites", 32'(wr_addr_q.size()), 32'd0);

    // Throttled host: valid high one cycle in three.
    clear_writes();
    pulse_start();
    acc0 = accept_cnt;
    cs = frame_csum(16'd1, 32'h00A00513, 32'h0);
    send_byte(8'h01); idle_host(); idle_host();
    send_byte(8'h00); idle_host(); idle_host();
    send_byte(8'h13); idle_host(); idle_host();
    send_byte(8'h05); idle_host(); idle_host();
    send_byte(8'hA0); idle_host(); idle_host();
    send_byte(8'h00); idle_host(); idle_host();
    send_byte(cs);    idle_host(); idle_host();
    checkOutput("thr_accepts", 32'(accept_cnt - acc0), 32'd7);
    checkOutput("thr_done", 32'(done_o), 32'd1);
    checkOutput("thr_wcnt", 32'(word_cnt_o), 32'd1);
    checkOutput("thr_nwrites", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() == 1) begin
      checkOutput("thr_addr0", wr_addr_q[0], 32'h0);
      checkOutput("thr_data0", wr_data_q[0], 32'h00A00513);
    end

    // Reset after the 2nd data byte: outputs fall back asynchronously.
    clear_writes();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05);
    idle_host();
    #2 rst_i = 1'b1;
    #1;
    checkOutput("mrst_ready", 32'(byte_ready_o), 32'd0);
    checkOutput("mrst_busy", 32'(busy_o), 32'd0);
    checkOutput("mrst_hold", 32'(cpu_hold_o), 32'd1);
    checkOutput("mrst_we", 32'(mem_we_o), 32'd0);
    checkOutput("mrst_wcnt", 32'(word_cnt_o), 32'd0);
    checkOutput("mrst_addr", mem_addr_o, BASE);
    checkOutput("mrst_data", mem_data_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("mrst_nwrites", 32'(wr_addr_q.size()), 32'd0);

    // Fresh frame with start_i asserted while busy; it must be ignored.
    clear_writes();
    pulse_start();
    cs = frame_csum(16'd1, 32'hCAFEF00D, 32'h0);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h0D);
    start_i = 1'b1;
    send_byte(8'hF0);
    send_byte(8'hFE);
    start_i = 1'b0;
    send_byte(8'hCA);
    send_byte(cs);
    idle_host();
    @(negedge clk_i);
    checkOutput("rs_done", 32'(done_o), 32'd1);
    checkOutput("rs_hold", 32'(cpu_hold_o), 32'd0);
    checkOutput("rs_wcnt", 32'(word_cnt_o), 32'd1);
    checkOutput("rs_nwrites", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() == 1) begin
      checkOutput("rs_addr0", wr_addr_q[0], 32'h0);
      checkOutput("rs_data0", wr_data_q[0], 32'hCAFEF00D);
    end

    // Restart from DONE clears done_o and word_cnt_o and raises cpu_hold_o.
    pulse_start();
    checkOutput("re_done", 32'(done_o), 32'd0);
    checkOutput("re_hold", 32'(cpu_hold_o), 32'd1);
    checkOutput("re_wcnt", 32'(word_cnt_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
